// File: rtl/rgb_slice_writer_if.sv
// RAM write port between the RGB slice writer and the slice RAM.
//   ram_addr      write address (word address)
//   ram_data      packed pixel, zero-extended to RAM_DATA_WIDTH
//   write_enable  one-cycle write strobe; addr/data are valid only while it is high
// master: the writer (drives the port); slave: the RAM (receives it).
interface rgb_slice_writer_if #(
   parameter int unsigned RAM_ADDR_WIDTH = 32,
   parameter int unsigned RAM_DATA_WIDTH = 16
);
   logic [RAM_ADDR_WIDTH-1:0] ram_addr;
   logic [RAM_DATA_WIDTH-1:0] ram_data;
   logic                      write_enable;

   modport master (
      output ram_addr,
      output ram_data,
      output write_enable
   );

   modport slave (
      input ram_addr,
      input ram_data,
      input write_enable
   );
endinterface

// File: rtl/rgb_slice_writer.sv
// RGB-to-RAM slice writer.
// Samples the parallel RGB bus on rgb_clk, packs each active pixel (hsync & vsync both high)
// into a 16-bit format chosen when capture is enabled, and writes whole slices of
// IMAGE_WIDTH*IMAGE_HEIGHT pixels into a RAM holding IMAGE_IN_RAM slices. Capture always
// starts on a vsync falling edge; a frame that ends before a slice is complete is discarded
// and its slot rewritten. In ring mode the RAM is reused from slice 0, otherwise capture
// stops once the RAM is full.
// Ports:
//   rgb_clk       pixel clock, all logic on the rising edge
//   nrst          asynchronous active-low reset
//   rgb           {R[7:0], G[7:0], B[7:0]}
//   hsync/vsync   low = horizontal/vertical blanking
//   pix_fmt       0 RGB565, 1 RGB555, 2 RGB444, 3 G8 mono; latched when capture is enabled
//   ring_mode     1: wrap to slice 0 at the end of the RAM, 0: stop when full
//   rgb_enable    1 = capture allowed; 0 returns to idle and clears all progress
//   ram           RAM write port (master side)
//   stream_ready  enough slices written for the reader to start; sticky while enabled
//   slice_done    one-cycle pulse alongside the write of the last pixel of a slice
//   slice_count   slices completed since enable, saturating at 255
//   frame_error   one-cycle pulse when a short frame is discarded
module rgb_slice_writer #(
   parameter int unsigned RAM_ADDR_WIDTH       = 32,
   parameter int unsigned RAM_DATA_WIDTH       = 16,
   parameter int unsigned IMAGE_WIDTH          = 40,
   parameter int unsigned IMAGE_HEIGHT         = 48,
   parameter int unsigned IMAGE_IN_RAM         = 18,
   parameter int unsigned SLICES_BEFORE_STREAM = 1
) (
   input  logic                 rgb_clk,
   input  logic                 nrst,
   input  logic [23:0]          rgb,
   input  logic                 hsync,
   input  logic                 vsync,
   input  logic [1:0]           pix_fmt,
   input  logic                 ring_mode,
   input  logic                 rgb_enable,
   rgb_slice_writer_if.master   ram,
   output logic                 stream_ready,
   output logic                 slice_done,
   output logic [7:0]           slice_count,
   output logic                 frame_error
);

   localparam int unsigned ImageSize = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int unsigned RamWords  = ImageSize * IMAGE_IN_RAM;
   localparam int unsigned CntW      = (ImageSize > 1) ? $clog2(ImageSize) : 1;

   localparam logic [CntW-1:0]           LastPix  = CntW'(ImageSize - 1);
   localparam logic [RAM_ADDR_WIDTH-1:0] SliceLen = RAM_ADDR_WIDTH'(ImageSize);
   localparam logic [RAM_ADDR_WIDTH-1:0] RamEnd   = RAM_ADDR_WIDTH'(RamWords);
   localparam logic [7:0]                StreamAt = 8'(SLICES_BEFORE_STREAM);

   typedef enum logic [1:0] {
      StIdle,
      StSync,
      StCapture,
      StFull
   } state_e;

   state_e                    state_q;
   logic [1:0]                fmt_q;
   logic                      vsync_q;
   logic [CntW-1:0]           pixel_cnt_q;
   logic [RAM_ADDR_WIDTH-1:0] base_q;
   // A slice has been completed in the current frame; remaining pixels are dropped.
   logic                      frame_taken_q;
   logic [7:0]                slice_count_q;
   logic                      stream_ready_q;
   logic                      write_enable_q;
   logic [RAM_ADDR_WIDTH-1:0] ram_addr_q;
   logic [RAM_DATA_WIDTH-1:0] ram_data_q;
   logic                      slice_done_q;
   logic                      frame_error_q;

   logic                      active;
   logic                      vs_fall;
   logic                      last_pix;
   logic [RAM_ADDR_WIDTH-1:0] next_base;
   logic [15:0]               pix16;
   logic [RAM_DATA_WIDTH-1:0] pix_word;

   assign active    = hsync & vsync;
   assign vs_fall   = vsync_q & ~vsync;
   assign last_pix  = (pixel_cnt_q == LastPix);
   assign next_base = base_q + SliceLen;

   always_comb begin
      pix16 = 16'h0000;
      unique case (fmt_q)
         2'd0: pix16 = {rgb[23:19], rgb[15:10], rgb[7:3]};
         2'd1: pix16 = {1'b0, rgb[23:19], rgb[15:11], rgb[7:3]};
         2'd2: pix16 = {4'b0000, rgb[23:20], rgb[15:12], rgb[7:4]};
         2'd3: pix16 = {8'h00, rgb[15:8]};
         default: pix16 = 16'h0000;
      endcase
      pix_word = RAM_DATA_WIDTH'(pix16);
   end

   always_ff @(posedge rgb_clk or negedge nrst) begin
      if (!nrst) begin
         state_q        <= StIdle;
         fmt_q          <= 2'd0;
         vsync_q        <= 1'b0;
         pixel_cnt_q    <= '0;
         base_q         <= '0;
         frame_taken_q  <= 1'b0;
         slice_count_q  <= 8'd0;
         stream_ready_q <= 1'b0;
         write_enable_q <= 1'b0;
         ram_addr_q     <= '0;
         ram_data_q     <= '0;
         slice_done_q   <= 1'b0;
         frame_error_q  <= 1'b0;
      end else begin
         vsync_q        <= vsync;
         write_enable_q <= 1'b0;
         slice_done_q   <= 1'b0;
         frame_error_q  <= 1'b0;

         if (!rgb_enable) begin
            state_q        <= StIdle;
            pixel_cnt_q    <= '0;
            base_q         <= '0;
            frame_taken_q  <= 1'b0;
            slice_count_q  <= 8'd0;
            stream_ready_q <= 1'b0;
         end else begin
            // slice_count already holds the new total, so this rises one cycle after it.
            if (slice_count_q >= StreamAt) begin
               stream_ready_q <= 1'b1;
            end

            unique case (state_q)
               StIdle: begin
                  fmt_q   <= pix_fmt;
                  state_q <= StSync;
               end

               StSync: begin
                  if (vs_fall) begin
                     frame_taken_q <= 1'b0;
                     state_q       <= StCapture;
                  end
               end

               StCapture: begin
                  if (vs_fall) begin
                     // Short frame: rewind to the start of the current slot.
                     if (pixel_cnt_q != '0) begin
                        frame_error_q <= 1'b1;
                     end
                     pixel_cnt_q   <= '0;
                     frame_taken_q <= 1'b0;
                  end else if (active && !frame_taken_q) begin
                     write_enable_q <= 1'b1;
                     ram_addr_q     <= base_q + RAM_ADDR_WIDTH'(pixel_cnt_q);
                     ram_data_q     <= pix_word;
                     if (last_pix) begin
                        slice_done_q  <= 1'b1;
                        pixel_cnt_q   <= '0;
                        frame_taken_q <= 1'b1;
                        if (slice_count_q != 8'hFF) begin
                           slice_count_q <= slice_count_q + 8'd1;
                        end
                        if (next_base == RamEnd) begin
                           base_q <= '0;
                           if (!ring_mode) begin
                              state_q <= StFull;
                           end
                        end else begin
                           base_q <= next_base;
                        end
                     end else begin
                        pixel_cnt_q <= pixel_cnt_q + 1'b1;
                     end
                  end
               end

               StFull: begin
                  // Held until rgb_enable drops.
               end

               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign ram.write_enable = write_enable_q;
   assign ram.ram_addr     = ram_addr_q;
   assign ram.ram_data     = ram_data_q;
   assign stream_ready     = stream_ready_q;
   assign slice_done       = slice_done_q;
   assign slice_count      = slice_count_q;
   assign frame_error      = frame_error_q;

endmodule
